// File: rtl/operand_fetch.sv
// Operand fetch: streams len op1/op2 pairs from the scratchpad SRAM read ports
// to the compute core through a small credit-controlled pair FIFO.
module operand_fetch #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] op1_base,
    input  logic [ADDR_WIDTH-1:0] op2_base,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  op1_ren,
    output logic [ADDR_WIDTH-1:0] op1_radr,
    input  logic [DATA_WIDTH-1:0] op1_rdata,
    output logic                  op2_ren,
    output logic [ADDR_WIDTH-1:0] op2_radr,
    input  logic [DATA_WIDTH-1:0] op2_rdata,
    output logic                  pair_valid,
    input  logic                  pair_ready,
    output logic [DATA_WIDTH-1:0] pair_op1,
    output logic [DATA_WIDTH-1:0] pair_op2,
    output logic                  pair_last
);
    localparam int LW = ADDR_WIDTH + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;
    state_t r_state, w_state_nxt;

    logic [LW-1:0]         r_len, r_issued, r_accepted;
    logic [ADDR_WIDTH-1:0] r_op1_radr, r_op2_radr;
    logic                  r_ren, r_ren_last;
    logic                  r_cap, r_cap_last;
    logic                  r_zero_done;

    logic [DATA_WIDTH-1:0] r_mem_op1 [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_op2 [FIFO_DEPTH];
    logic                  r_mem_last [FIFO_DEPTH];
    logic [PW-1:0]         r_wp, r_rp;
    logic [CW-1:0]         r_cnt;

    logic          w_fifo_nempty, w_valid, w_pop, w_push, w_mem_pop;
    logic          w_last_hs, w_credit, w_start_go, w_start_zero, w_issue_more;
    logic [LW-1:0] w_outst;

    // r_cap marks the cycle the SRAM data is on rdata; it is presented directly
    // when the FIFO is empty so the first pair appears without an extra stage.
    assign w_fifo_nempty = (r_cnt != '0);
    assign w_valid       = w_fifo_nempty | r_cap;
    assign w_pop         = w_valid & pair_ready;
    assign w_mem_pop     = w_pop & w_fifo_nempty;
    assign w_push        = r_cap & ~(~w_fifo_nempty & w_pop);

    // Outstanding pairs (issued but not yet accepted) after this cycle's pop
    // must leave room for the read being decided now.
    assign w_outst      = r_issued - r_accepted - LW'(w_pop);
    assign w_credit     = (w_outst < LW'(FIFO_DEPTH));
    assign w_start_go   = (r_state == S_IDLE) & start & (len != '0);
    assign w_start_zero = (r_state == S_IDLE) & start & (len == '0);
    assign w_issue_more = (r_state == S_ISSUE) & (r_issued != r_len) & w_credit;
    assign w_last_hs    = w_pop & (r_state != S_IDLE) & ((r_accepted + LW'(1)) == r_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_go) w_state_nxt = S_ISSUE;
            S_ISSUE: if (r_issued == r_len) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_last_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len       <= '0;
            r_issued    <= '0;
            r_accepted  <= '0;
            r_op1_radr  <= '0;
            r_op2_radr  <= '0;
            r_ren       <= 1'b0;
            r_ren_last  <= 1'b0;
            r_cap       <= 1'b0;
            r_cap_last  <= 1'b0;
            r_zero_done <= 1'b0;
        end else begin
            r_ren       <= w_start_go | w_issue_more;
            r_cap       <= r_ren;
            r_cap_last  <= r_ren_last;
            r_zero_done <= w_start_zero;
            if (w_start_go) begin
                r_len      <= len;
                r_issued   <= LW'(1);
                r_op1_radr <= op1_base;
                r_op2_radr <= op2_base;
                r_ren_last <= (len == LW'(1));
            end else if (w_issue_more) begin
                r_issued   <= r_issued + LW'(1);
                r_op1_radr <= r_op1_radr + ADDR_WIDTH'(1);
                r_op2_radr <= r_op2_radr + ADDR_WIDTH'(1);
                r_ren_last <= ((r_issued + LW'(1)) == r_len);
            end else begin
                r_ren_last <= 1'b0;
            end
            if (w_start_go)  r_accepted <= '0;
            else if (w_pop)  r_accepted <= r_accepted + LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push)    r_wp <= r_wp + PW'(1);
            if (w_mem_pop) r_rp <= r_rp + PW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_mem_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op1[r_wp]  <= op1_rdata;
            r_mem_op2[r_wp]  <= op2_rdata;
            r_mem_last[r_wp] <= r_cap_last;
        end
    end

    assign op1_ren    = r_ren;
    assign op2_ren    = r_ren;
    assign op1_radr   = r_op1_radr;
    assign op2_radr   = r_op2_radr;
    assign pair_valid = w_valid;
    assign pair_op1   = w_fifo_nempty ? r_mem_op1[r_rp] : (r_cap ? op1_rdata : '0);
    assign pair_op2   = w_fifo_nempty ? r_mem_op2[r_rp] : (r_cap ? op2_rdata : '0);
    assign pair_last  = w_fifo_nempty ? r_mem_last[r_rp] : (r_cap & r_cap_last);
    assign done       = w_last_hs | r_zero_done;
    assign busy       = (r_state != S_IDLE) & ~w_last_hs;
endmodule
